audio_i2s_rx: RTL and testbench
===============================

Name: audio_i2s_rx

Overview:
- Master-mode I2S receiver that deserialises the ADC bit stream into the 18-bit left/right sample pair and a one-cycle sample strobe.
- Outputs connect directly to the DSP core inputs: left_in, right_in and data_en.
- Generates bclk and lrck for the codec from the system clock.
- Frame format: 64 bclk periods, 32 slots per channel, MSB first. Only the 18 most-significant bits of each channel are kept.

Parameters:
- BCLK_HALF, 2, system clock cycles per bclk half-period. Must be >= 1. With a 12.288 MHz clock the default gives bclk = 3.072 MHz and a 48 kHz frame.

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-high reset
- adc_sdata  input  1  serial data from the codec ADC; changes after bclk falling edge
- bclk  output  1  bit clock to the codec
- lrck  output  1  frame clock to the codec; 0 = left slots, 1 = right slots
- left_out  output  18  last complete left sample, two's complement
- right_out  output  18  last complete right sample, two's complement
- data_en  output  1  one-cycle strobe; left_out/right_out are updated in the same cycle

Behaviour:
- Reset (asynchronous, active-high): div_cnt=0, bclk=0, bit_cnt=0, lrck=0, both shift registers=0, left_out=0, right_out=0, data_en=0. All outputs are registered.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1 and wraps.
  - At wrap, bclk toggles.
  - rise_stb = cycle in which bclk goes 0->1; fall_stb = cycle in which bclk goes 1->0.
- Slot counter:
  - bit_cnt (6 bits, 0..63) increments on fall_stb and wraps from 63 to 0.
  - lrck is registered on fall_stb as bit 5 of the new bit_cnt value, so it changes together with bclk falling.
  - Frame period = 128*BCLK_HALF clocks (256 at default).
- Sampling: adc_sdata is sampled on the clock edge of rise_stb. No extra synchroniser is used, because the data is launched from our own bclk.
- I2S slot mapping (one-bclk delay after an lrck edge):
  - left bits [17:0] are in slots 1..18, MSB in slot 1;
  - right bits [17:0] are in slots 33..50;
  - slots 0, 19..32 and 51..63 are ignored.
- Each captured bit shifts into the matching 18-bit register, MSB first.
- Output update:
  - On the rise_stb that samples slot 50, the next clock edge loads left_out from the left register and right_out from the completed right register, and sets data_en=1.
  - data_en returns to 0 on the following edge: exactly one cycle high, once per frame.
  - Outputs hold their values between strobes.
- Latency: data_en rises one clock after the bclk rise that carries the right-channel LSB.
- First frame after reset is valid: the first data_en arrives at slot 50 of frame 0.
- Reset asserted mid-frame:
  - everything returns to its reset values immediately and partial samples are discarded;
  - after release the frame restarts at slot 0 with lrck=0;
  - no data_en occurs before slot 50 of the new frame.
- BCLK_HALF=1: bclk toggles every clock; rise_stb and fall_stb alternate each cycle; the rules above are unchanged.

Optional Feature:
- Macro: AUDIO_RX_LEFTJUST_EN.
- Defined: left-justified format with no one-bit delay:
  - left in slots 0..17, right in slots 32..49;
  - data_en follows the sampling of slot 49.
- Undefined: standard I2S mapping as above.
- Divider, lrck and reset behaviour are identical in both builds.

Test Plan:
1. Reset behaviour: hold reset 10 cycles -> bclk=0, lrck=0, data_en=0, left_out=0, right_out=0. Release reset -> first bclk rise after BCLK_HALF clocks; lrck first goes high on the fall into slot 32.
2. Known pattern: drive left 18'h2AAAA and right 18'h15555 in I2S slots -> data_en pulses one cycle with left_out=18'h2AAAA and right_out=18'h15555. Outputs are stable for the next 255 cycles.
3. Signed extremes: left 18'h20000 (-131072), right 18'h1FFFF (+131071) -> captured exactly. Slots 19..31 driven to 1 -> do not corrupt left_out.
4. Strobe cadence: run 8 frames at BCLK_HALF=2 -> data_en spacing exactly 256 cycles, width exactly 1 cycle. lrck duty is 50% (128 cycles each level).
5. Mid-frame reset: assert reset at slot 40 -> outputs go to 0 immediately. After release, no data_en until slot 50 of the restarted frame; the next sample is correct.
6. With AUDIO_RX_LEFTJUST_EN and the pattern of test 2 shifted one slot earlier -> the same output values. data_en occurs one bclk period earlier within the frame than in the I2S build.

Source files
------------

// File: rtl/audio_i2s_rx.sv
// Master-mode I2S receiver: generates bclk/lrck and deserialises 18-bit left/right samples.
// Define AUDIO_RX_LEFTJUST_EN for left-justified framing (no one-bit delay after lrck edges).
module audio_i2s_rx #(
  parameter int unsigned BCLK_HALF = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        adc_sdata,
  output logic        bclk,
  output logic        lrck,
  output logic [17:0] left_out,
  output logic [17:0] right_out,
  output logic        data_en
);

  localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(BCLK_HALF - 1);

`ifdef AUDIO_RX_LEFTJUST_EN
  localparam logic [5:0] LeftFirst  = 6'd0;
  localparam logic [5:0] RightFirst = 6'd32;
`else
  localparam logic [5:0] LeftFirst  = 6'd1;
  localparam logic [5:0] RightFirst = 6'd33;
`endif
  localparam logic [5:0] RightLast = RightFirst + 6'd17;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            bclk_q, bclk_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic            lrck_q, lrck_d;
  logic [17:0]     left_sh_q, left_sh_d;
  logic [17:0]     right_sh_q, right_sh_d;
  logic [17:0]     left_out_q, left_out_d;
  logic [17:0]     right_out_q, right_out_d;
  logic            done_q, done_d;
  logic            data_en_q, data_en_d;

  logic       wrap, rise_stb, fall_stb, in_left, in_right;
  logic [5:0] left_off, right_off;

  always_comb begin
    wrap      = (div_cnt_q == DivMax);
    rise_stb  = wrap & ~bclk_q;
    fall_stb  = wrap & bclk_q;
    // Modular offsets make the slot-window test a single unsigned compare.
    left_off  = bit_cnt_q - LeftFirst;
    right_off = bit_cnt_q - RightFirst;
    in_left   = (left_off < 6'd18);
    in_right  = (right_off < 6'd18);

    div_cnt_d   = wrap ? '0 : div_cnt_q + DivW'(1);
    bclk_d      = bclk_q ^ wrap;
    bit_cnt_d   = bit_cnt_q;
    lrck_d      = lrck_q;
    left_sh_d   = left_sh_q;
    right_sh_d  = right_sh_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    done_d      = 1'b0;
    data_en_d   = 1'b0;

    if (fall_stb) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrck_d    = bit_cnt_d[5];
    end

    // Data is launched by the codec off our own bclk, so no synchroniser is needed.
    if (rise_stb) begin
      if (in_left)  left_sh_d  = {left_sh_q[16:0], adc_sdata};
      if (in_right) right_sh_d = {right_sh_q[16:0], adc_sdata};
      done_d = (bit_cnt_q == RightLast);
    end

    if (done_q) begin
      left_out_d  = left_sh_q;
      right_out_d = right_sh_q;
      data_en_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= 6'd0;
      lrck_q      <= 1'b0;
      left_sh_q   <= 18'd0;
      right_sh_q  <= 18'd0;
      left_out_q  <= 18'd0;
      right_out_q <= 18'd0;
      done_q      <= 1'b0;
      data_en_q   <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrck_q      <= lrck_d;
      left_sh_q   <= left_sh_d;
      right_sh_q  <= right_sh_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      done_q      <= done_d;
      data_en_q   <= data_en_d;
    end
  end

  assign bclk      = bclk_q;
  assign lrck      = lrck_q;
  assign left_out  = left_out_q;
  assign right_out = right_out_q;
  assign data_en   = data_en_q;

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Bench for audio_i2s_rx: a codec model drives random frames, a monitor scoreboards the strobes.
module tb_audio_i2s_rx;

  localparam int unsigned BclkHalf = 2;
  localparam int FramePeriod = 128 * BclkHalf;
`ifdef AUDIO_RX_LEFTJUST_EN
  localparam int LFirst = 0;
  localparam int RFirst = 32;
`else
  localparam int LFirst = 1;
  localparam int RFirst = 33;
`endif
  localparam int LastSlot = RFirst + 17;

  logic        clock;
  logic        reset;
  logic        adc_sdata;
  logic        bclk;
  logic        lrck;
  logic [17:0] left_out;
  logic [17:0] right_out;
  logic        data_en;

  audio_i2s_rx #(.BCLK_HALF(BclkHalf)) dut (
    .clock     (clock),
    .reset     (reset),
    .adc_sdata (adc_sdata),
    .bclk      (bclk),
    .lrck      (lrck),
    .left_out  (left_out),
    .right_out (right_out),
    .data_en   (data_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Codec model: slot index advances on every bclk fall, frame words chosen per frame.
  logic [35:0] exp_q[$];
  int          slot = 0;
  int          frame_idx = 0;
  logic [17:0] cur_l, cur_r;
  logic [63:0] fill_bits;

  function automatic logic model_bit(input int s, input logic [17:0] l, input logic [17:0] r,
                                     input logic [63:0] fill);
    if (s >= LFirst && s < LFirst + 18) return l[17 - (s - LFirst)];
    if (s >= RFirst && s < RFirst + 18) return r[17 - (s - RFirst)];
    return fill[s];
  endfunction

  task automatic new_frame();
    fill_bits = {$urandom, $urandom};
    if (frame_idx == 0) begin
      cur_l = 18'h2AAAA;
      cur_r = 18'h15555;
    end else if (frame_idx == 1) begin
      cur_l     = 18'h20000;
      cur_r     = 18'h1FFFF;
      fill_bits = '1;
    end else begin
      cur_l = 18'($urandom);
      cur_r = 18'($urandom);
    end
    frame_idx++;
    exp_q.push_back({cur_l, cur_r});
  endtask

  always @(negedge bclk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      slot = 0;
      new_frame();
    end else begin
      slot = (slot + 1) % 64;
      if (slot == 0) new_frame();
    end
    adc_sdata = model_bit(slot, cur_l, cur_r, fill_bits);
  end

  // Monitor: scoreboard, strobe cadence, output hold and lrck against the codec's slot.
  int          cyc = 0;
  int          last_en = -1;
  int          en_count = 0;
  logic        prev_en = 1'b0;
  logic [35:0] held = '0;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      held    = '0;
      last_en = -1;
      prev_en = 1'b0;
    end else begin
      chk("lrck", {35'd0, lrck}, {35'd0, (slot >= 32)});
      if (prev_en) chk("en_width", {35'd0, data_en}, 36'd0);
      if (data_en) begin
        en_count++;
        chk("en_slot", 36'(slot), 36'(LastSlot));
        if (last_en >= 0) chk("en_spacing", 36'(cyc - last_en), 36'(FramePeriod));
        last_en = cyc;
        chk("sb_pending", {35'd0, (exp_q.size() > 0)}, 36'd1);
        if (exp_q.size() > 0) begin
          held = exp_q.pop_front();
          chk("sample", {left_out, right_out}, held);
        end
      end else begin
        chk("hold", {left_out, right_out}, held);
      end
      prev_en = data_en;
    end
  end

  int base;

  initial begin
    reset     = 1'b0;
    adc_sdata = 1'b0;
    #1 reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("rst_bclk",  {35'd0, bclk}, 36'd0);
    chk("rst_lrck",  {35'd0, lrck}, 36'd0);
    chk("rst_en",    {35'd0, data_en}, 36'd0);
    chk("rst_left",  {18'd0, left_out}, 36'd0);
    chk("rst_right", {18'd0, right_out}, 36'd0);

    #1 reset = 1'b0;
    for (int i = 1; i <= BclkHalf; i++) begin
      @(posedge clock);
      #1 chk("first_rise", {35'd0, bclk}, {35'd0, (i == BclkHalf)});
    end

    for (int i = 0; i < 8 * FramePeriod + 600 && en_count < 8; i++) @(negedge clock);
    chk("strobes8", 36'(en_count), 36'd8);

    // Reset in the middle of the right-channel slots.
    for (int i = 0; i < 2 * FramePeriod && slot != 40; i++) @(negedge clock);
    chk("reach_slot40", 36'(slot), 36'd40);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_left",  {18'd0, left_out}, 36'd0);
    chk("mid_rst_right", {18'd0, right_out}, 36'd0);
    chk("mid_rst_en",    {35'd0, data_en}, 36'd0);
    chk("mid_rst_bclk",  {35'd0, bclk}, 36'd0);
    chk("mid_rst_lrck",  {35'd0, lrck}, 36'd0);
    repeat (5) @(negedge clock);
    #1 reset = 1'b0;

    base = en_count;
    for (int i = 0; i < 3 * FramePeriod + 600 && en_count < base + 3; i++) @(negedge clock);
    chk("strobes_after_rst", 36'(en_count - base), 36'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
